adc_phase_soc_seq: RTL

- Parametrised successor of the ADC clock/SOC generator for the 12-bit SAR ADC front-end.
- Divides CLOCK into two registered, non-overlapping conversion phases (PHI1/PHI2) plus their complements (PHI3/PHI4), with programmable dead time.
- Runs a start-of-conversion sequencer that aligns a stretched SOC_LF pulse to the phase frame, and supports bursts of N conversions, abort, and busy/done status.

---
 rtl/adc_seq_pkg.sv | 29 ++
 rtl/adc_phase_gen.sv | 47 ++++
 rtl/adc_phase_soc_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/adc_seq_pkg.sv
// Shared state encoding and parameter helpers for the ADC phase/SOC sequencer.
// Pure declarations; no logic, no latency, no backpressure.
package adc_seq_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARM      = 3'd1,
      ACTIVE   = 3'd2,
      GAP      = 3'd3,
      ENDCOUNT = 3'd4
   } seq_state_t;

   // Phase half-period H in CLOCK cycles.
   function automatic int half_period(input int div_log2);
      return 1 << div_log2;
   endfunction

   // SOC_LF high length L in CLOCK cycles.
   function automatic int soc_len(input int soc_len_log2);
      return 1 << soc_len_log2;
   endfunction

   // Dead time must leave part of each half-period high; SOC_LF must fit in one frame.
   function automatic bit cfg_ok(input int div_log2, input int dead_cyc, input int soc_len_log2);
      return (dead_cyc >= 1) && (dead_cyc < half_period(div_log2)) &&
             (soc_len(soc_len_log2) <= 2 * half_period(div_log2));
   endfunction

endpackage

// File: rtl/adc_phase_gen.sv
// Frame counter plus registered non-overlapping PHI1/PHI2 and their complements.
// Outputs are flops decoded from the previous div_cnt; free-running, no backpressure.
module adc_phase_gen
   import adc_seq_pkg::*;
#(
   parameter int DIV_LOG2 = 9,
   parameter int DEAD_CYC = 2
)(
   input  logic                CLOCK,
   input  logic                RESETB,
   output logic [DIV_LOG2:0]   div_cnt,
   output logic                PHI1,
   output logic                PHI2,
   output logic                PHI3,
   output logic                PHI4
);

   localparam int H  = half_period(DIV_LOG2);
   localparam int CW = DIV_LOG2 + 1;
   localparam logic [CW-1:0] P1_LO = CW'(DEAD_CYC);
   localparam logic [CW-1:0] P1_HI = CW'(H - 1);
   localparam logic [CW-1:0] P2_LO = CW'(H + DEAD_CYC);

   logic phi1_nxt;
   logic phi2_nxt;

   // div_cnt spans exactly one frame, so natural overflow is the 2H-1 -> 0 wrap.
   assign phi1_nxt = (div_cnt >= P1_LO) && (div_cnt <= P1_HI);
   assign phi2_nxt = (div_cnt >= P2_LO);

   always_ff @(posedge CLOCK or negedge RESETB) begin
      if (!RESETB) begin
         div_cnt <= '0;
         PHI1    <= 1'b0;
         PHI2    <= 1'b0;
         PHI3    <= 1'b1;
         PHI4    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + CW'(1);
         PHI1    <= phi1_nxt;
         PHI2    <= phi2_nxt;
         PHI3    <= !phi2_nxt;
         PHI4    <= !phi1_nxt;
      end
   end

endmodule

// File: rtl/adc_phase_soc_seq.sv
// ADC phase clocks plus a burst SOC sequencer aligning SOC_LF to frame start.
// Start is accepted one edge after the SOC rise; edges while BUSY are dropped, not queued.
module adc_phase_soc_seq
   import adc_seq_pkg::*;
#(
   parameter int DIV_LOG2     = 9,
   parameter int DEAD_CYC     = 2,
   parameter int SOC_LEN_LOG2 = 10,
   parameter int CNT_W        = 8
)(
   input  logic             CLOCK,
   input  logic             RESETB,
   input  logic             SOC,
   input  logic [CNT_W-1:0] BURST_N,
   input  logic             ABORT,
   output logic             PHI1,
   output logic             PHI2,
   output logic             PHI3,
   output logic             PHI4,
   output logic             SOC_LF,
   output logic             BUSY,
   output logic             DONE,
   output logic [CNT_W-1:0] CONV_IDX
);

   localparam int H  = half_period(DIV_LOG2);
   localparam int CW = DIV_LOG2 + 1;
   localparam logic [CW-1:0] FRAME_LAST = CW'(2 * H - 1);

   if (!cfg_ok(DIV_LOG2, DEAD_CYC, SOC_LEN_LOG2)) begin : g_cfg_err
      $error("adc_phase_soc_seq: need 1 <= DEAD_CYC < H and L <= 2H");
   end

   logic [CW-1:0]           div_cnt;
   seq_state_t              state;
   seq_state_t              state_nxt;
   logic                    soc_q;
   logic [CNT_W-1:0]        target;
   logic [SOC_LEN_LOG2-1:0] len_cnt;
   logic                    start;
   logic                    frame_end;
   logic                    len_last;
   logic                    last_conv;

   adc_phase_gen #(
      .DIV_LOG2 (DIV_LOG2),
      .DEAD_CYC (DEAD_CYC)
   ) u_phase_gen (
      .CLOCK   (CLOCK),
      .RESETB  (RESETB),
      .div_cnt (div_cnt),
      .PHI1    (PHI1),
      .PHI2    (PHI2),
      .PHI3    (PHI3),
      .PHI4    (PHI4)
   );

   assign start     = SOC && !soc_q;
   assign frame_end = (div_cnt == FRAME_LAST);
   assign len_last  = &len_cnt;
   assign last_conv = ((CONV_IDX + CNT_W'(1)) == target);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (start) state_nxt = ARM;
         ARM:      if (frame_end) state_nxt = ACTIVE;
         ACTIVE:   if (len_last) state_nxt = last_conv ? ENDCOUNT : GAP;
         GAP:      state_nxt = ARM;
         ENDCOUNT: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (ABORT && (state != IDLE)) state_nxt = IDLE;
   end

   // Status outputs are registered from the next state so they line up with it exactly.
   always_ff @(posedge CLOCK or negedge RESETB) begin
      if (!RESETB) begin
         state    <= IDLE;
         soc_q    <= 1'b0;
         target   <= '0;
         len_cnt  <= '0;
         CONV_IDX <= '0;
         SOC_LF   <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         state  <= state_nxt;
         soc_q  <= SOC;
         SOC_LF <= (state_nxt == ACTIVE);
         BUSY   <= (state_nxt != IDLE);
         DONE   <= (state_nxt == ENDCOUNT);
         if ((state == IDLE) && start) begin
            target   <= (BURST_N == '0) ? CNT_W'(1) : BURST_N;
            CONV_IDX <= '0;
         end
         if ((state_nxt == ACTIVE) && (state != ACTIVE)) begin
            len_cnt <= '0;
         end else if (state == ACTIVE) begin
            len_cnt <= len_cnt + SOC_LEN_LOG2'(1);
         end
         if ((state == ACTIVE) && (state_nxt == GAP)) begin
            CONV_IDX <= CONV_IDX + CNT_W'(1);
         end
      end
   end

endmodule
